// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter-side defaults and the occupancy-width helper
package arb_pkg;
  localparam int DATAW = 64;
  localparam int N_REQ = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/req_fifo_mem.sv
// req_fifo_mem: unreset register array with one write port and an asynchronous read port
module req_fifo_mem #(
  parameter int DATAW = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [DATAW-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [DATAW-1:0] o_rdata
);
  logic [DATAW-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/req_fifo.sv
// req_fifo: per-requester FWFT buffer feeding one valid/data lane of the round-robin arbiter
module req_fifo
  import arb_pkg::*;
#(
  parameter int DATAW     = arb_pkg::DATAW,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATAW-1:0]            i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATAW-1:0]            o_data,
  output logic [cnt_w(DEPTH)-1:0]     o_count,
  output logic                        o_afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign o_ready = count != CW'(DEPTH);
  assign o_valid = count != '0;
  assign o_count = count;
  assign o_afull = count >= CW'(AFULL_LVL);
  assign push = i_valid & o_ready;
  assign pop = o_valid & i_ready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  req_fifo_mem #(.DATAW(DATAW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk(i_clk),
    .i_we(push),
    .i_waddr(wr_ptr),
    .i_wdata(i_data),
    .i_raddr(rd_ptr),
    .o_rdata(o_data)
  );
endmodule

// File: tb/tb_req_fifo.sv
// tb_req_fifo: directed scenarios for req_fifo, including a two-lane hold-grant arbiter model
module tb_req_fifo;
  logic clk = 0, rst_n = 0;
  logic valid = 0, ready = 0;
  logic [63:0] data = '0;
  logic o_ready, o_valid, o_afull;
  logic [63:0] o_data;
  logic [2:0] o_count;
  logic valid_b = 0, ready_b = 0;
  logic [63:0] data_b = '0;
  logic o_ready_b, o_valid_b, o_afull_b;
  logic [63:0] o_data_b;
  logic [2:0] o_count_b;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  req_fifo #(.DATAW(64), .DEPTH(4), .AFULL_LVL(3)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready), .i_data(data),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_count(o_count), .o_afull(o_afull)
  );
  req_fifo #(.DATAW(64), .DEPTH(4), .AFULL_LVL(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(o_ready_b), .i_data(data_b),
    .o_valid(o_valid_b), .i_ready(ready_b), .o_data(o_data_b), .o_count(o_count_b), .o_afull(o_afull_b)
  );

  // overflow/underflow guards: ready must drop at full, valid must drop at empty
  always @(posedge clk)
    if (rst_n && ((o_count == 4 && o_ready) || (o_count == 0 && o_valid))) begin
      $display("FAIL guard count=%0d ready=%0b valid=%0b", o_count, o_ready, o_valid);
      fails++;
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({o_valid, o_ready, o_count, o_afull} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      $display("FAIL reset got v=%0b r=%0b c=%0d af=%0b want v=0 r=1 c=0 af=0", o_valid, o_ready, o_count, o_afull);
      fails++;
    end
    step();
    rst_n = 1;
  endtask

  task automatic test_single();
    valid = 1; data = 64'hA5; ready = 0;
    step();
    valid = 0;
    tests++;
    if ({o_valid, o_count} !== {1'b1, 3'd1} || o_data !== 64'hA5) begin
      $display("FAIL single_push got v=%0b c=%0d d=%h want v=1 c=1 d=a5", o_valid, o_count, o_data);
      fails++;
    end
    ready = 1;
    step();
    ready = 0;
    tests++;
    if ({o_valid, o_count} !== {1'b0, 3'd0}) begin
      $display("FAIL single_pop got v=%0b c=%0d want v=0 c=0", o_valid, o_count);
      fails++;
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      valid = 1; data = 64'(i);
      step();
      tests++;
      if (o_count !== 3'(i) || o_afull !== (i >= 3) || o_ready !== (i != 4)) begin
        $display("FAIL fill_%0d got c=%0d af=%0b r=%0b want c=%0d af=%0b r=%0b",
                 i, o_count, o_afull, o_ready, i, i >= 3, i != 4);
        fails++;
      end
    end
    data = 64'h9;
    step();
    valid = 0;
    tests++;
    if (o_count !== 3'd4 || o_data !== 64'h1) begin
      $display("FAIL fill_reject got c=%0d head=%h want c=4 head=1", o_count, o_data);
      fails++;
    end
  endtask

  task automatic test_pop_full();
    logic [63:0] got [$];
    ready = 1; valid = 1; data = 64'h5;
    for (int s = 0; s < 5; s++) begin
      if (o_valid) got.push_back(o_data);
      step();
      if (s == 1) valid = 0;
      if (s < 2) begin
        tests++;
        if (o_count !== 3'd3 || o_ready !== 1'b1) begin
          $display("FAIL pop_full_cyc%0d got c=%0d r=%0b want c=3 r=1", s + 1, o_count, o_ready);
          fails++;
        end
      end
    end
    ready = 0;
    tests++;
    if (got.size() != 5 || o_count !== 3'd0) begin
      $display("FAIL drain_len got n=%0d c=%0d want n=5 c=0", got.size(), o_count);
      fails++;
    end else
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (got[k] !== 64'(k + 1)) begin
          $display("FAIL drain_%0d got %h want %h", k, got[k], k + 1);
          fails++;
        end
      end
  endtask

  task automatic test_stream();
    valid = 1; ready = 1;
    for (int k = 0; k < 20; k++) begin
      data = 64'h100 + 64'(k);
      step();
      tests++;
      if (o_count !== 3'd1 || o_valid !== 1'b1 || o_data !== 64'h100 + 64'(k)) begin
        $display("FAIL stream_%0d got c=%0d v=%0b d=%h want c=1 v=1 d=%h", k, o_count, o_valid, o_data, 64'h100 + 64'(k));
        fails++;
      end
    end
    valid = 0;
    step();
    ready = 0;
    tests++;
    if (o_count !== 3'd0) begin
      $display("FAIL stream_end got c=%0d want 0", o_count);
      fails++;
    end
  endtask

  task automatic test_async_reset();
    valid = 1; data = 64'hB1;
    step();
    data = 64'hB2;
    step();
    valid = 0;
    #2 rst_n = 0;
    #1;
    tests++;
    if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ready !== 1'b1) begin
      $display("FAIL async_rst got v=%0b c=%0d r=%0b want v=0 c=0 r=1", o_valid, o_count, o_ready);
      fails++;
    end
    rst_n = 1;
    valid = 1; data = 64'h77;
    step();
    valid = 0;
    tests++;
    if (o_data !== 64'h77 || o_count !== 3'd1) begin
      $display("FAIL post_rst got d=%h c=%0d want d=77 c=1", o_data, o_count);
      fails++;
    end
    ready = 1;
    step();
    ready = 0;
    tests++;
    if (o_valid !== 1'b0) begin
      $display("FAIL post_rst_stale got v=%0b want 0", o_valid);
      fails++;
    end
  endtask

  task automatic test_integration();
    logic [63:0] g0 [$], g1 [$];
    int gnt = 0;
    for (int k = 0; k < 3; k++) begin
      valid = 1; data = 64'h10 + 64'(k);
      valid_b = 1; data_b = 64'h20 + 64'(k);
      step();
    end
    valid = 0; valid_b = 0;
    for (int c = 0; c < 20 && g0.size() + g1.size() < 6; c++) begin
      if (!(gnt == 0 ? o_valid : o_valid_b)) gnt = 1 - gnt;
      ready = gnt == 0;
      ready_b = gnt == 1;
      if (o_valid && ready) g0.push_back(o_data);
      if (o_valid_b && ready_b) g1.push_back(o_data_b);
      step();
    end
    ready = 0; ready_b = 0;
    tests++;
    if (g0.size() != 3 || g1.size() != 3) begin
      $display("FAIL integ_count got n0=%0d n1=%0d want 3 3", g0.size(), g1.size());
      fails++;
    end else
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (g0[k] !== 64'h10 + 64'(k) || g1[k] !== 64'h20 + 64'(k)) begin
          $display("FAIL integ_%0d got %h %h want %h %h", k, g0[k], g1[k], 64'h10 + 64'(k), 64'h20 + 64'(k));
          fails++;
        end
      end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_pop_full();
    test_stream();
    test_async_reset();
    test_integration();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
